// File: rtl/axis_dma_buffer_pkg.sv
// ----------------------------------------------------------------------------
// axis_dma_buffer_pkg
// Shared definitions for the AXI4-Stream DMA store-and-forward buffer:
//   state_t  - controller state encoding
//   CMD_*    - encodings of the 2-bit DMA command field (3 is reserved, a NOP)
// ----------------------------------------------------------------------------
package axis_dma_buffer_pkg;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_IDLE,
        ST_IN,
        ST_IN_W1,
        ST_IN_W2,
        ST_OUT,
        ST_OUT_W1,
        ST_OUT_W2
    } state_t;

    localparam logic [1:0] CMD_NOP = 2'd0;
    localparam logic [1:0] CMD_IN  = 2'd1;
    localparam logic [1:0] CMD_OUT = 2'd2;

endpackage

// File: rtl/axis_buf_mem.sv
// ----------------------------------------------------------------------------
// axis_buf_mem
// DEPTH x DATA_W simple dual-port RAM with one write port and one read port.
// The read is registered: rd_data shows mem[rd_addr] the cycle after rd_en,
// and holds its value while rd_en is low.
// Ports:
//   clk, rst           clock, asynchronous active-high reset (read register only)
//   wr_en/wr_addr/wr_data   write port
//   rd_en/rd_addr/rd_data   read port, 1-cycle latency
// ----------------------------------------------------------------------------
module axis_buf_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset so it maps onto block/distributed
    // RAM; only the read output register is reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/axis_dma_buffer.sv
// ----------------------------------------------------------------------------
// axis_dma_buffer
// AXI4-Stream store-and-forward buffer under DMA control. An IN command
// captures up to len words (len 0 or > DEPTH means DEPTH) from the slave
// stream, stopping early on s_tlast. An OUT command replays the stored words
// in address order on the master stream with m_tlast on the final beat.
// Each transfer ends with a dma_valid 1->0->1 acknowledge and a done pulse.
//
// Optional feature, macro AXIS_SUM_EN: OUT appends one trailing beat holding
// the modulo-2^DATA_W sum of the stored words (accumulated during IN), and
// m_tlast moves to that beat. Undefined: no sum beat and no adder.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   en              block enable; low forces OFF next cycle
//   dma_valid       DMA handshake level
//   command, len    DMA command (NOP/IN/OUT) and load length
//   s_data/s_valid/s_tlast/s_ready   slave stream (capture)
//   m_data/m_valid/m_tlast/m_ready   master stream (replay)
//   word_count      words currently held
//   busy            high during IN/OUT and their acknowledge waits
//   done            one-cycle pulse when a transfer returns to IDLE
// ----------------------------------------------------------------------------
module axis_dma_buffer
    import axis_dma_buffer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int LEN_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              dma_valid,
    input  logic [1:0]        command,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_tlast,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_tlast,
    input  logic              m_ready,
    output logic [LEN_W-1:0]  word_count,
    output logic              busy,
    output logic              done
);

    localparam int               ADDR_W  = $clog2(DEPTH);
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

    state_t            state;
    logic [LEN_W-1:0]  target;
    // One bit wider than word_count so the optional sum beat still fits.
    logic [LEN_W:0]    rd_ptr;
    logic [LEN_W:0]    total_beats;
    logic [LEN_W:0]    wc_ext;
    logic              beat_in;
    logic              wr_en;
    logic              out_free;
    logic              load_beat;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;

    assign wc_ext = {1'b0, word_count};

`ifdef AXIS_SUM_EN
    logic [DATA_W-1:0] sum_q;
    logic              sum_beat;

    assign total_beats = wc_ext + 1'b1;
    // Both mux inputs and the select are registers, so m_data stays registered.
    assign m_data      = sum_beat ? sum_q : rd_data;
`else
    assign total_beats = wc_ext;
    assign m_data      = rd_data;
`endif

    assign beat_in   = (state == ST_IN) && s_valid && s_ready;
    // An abort (en low) wins over a beat arriving in the same cycle.
    assign wr_en     = beat_in && en;
    // The output register may take a new beat when empty or being consumed.
    assign out_free  = !m_valid || m_ready;
    assign load_beat = (state == ST_OUT) && en && out_free && (rd_ptr < total_beats);
    assign rd_en     = load_beat && (rd_ptr < wc_ext);

    axis_buf_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (word_count[ADDR_W-1:0]),
        .wr_data (s_data),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (rd_data)
    );

    // NOTE: every register in this block uses <=, so all branches read the
    // pre-edge values of word_count, rd_ptr and state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_OFF;
            s_ready    <= 1'b0;
            m_valid    <= 1'b0;
            m_tlast    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            word_count <= '0;
            target     <= '0;
            rd_ptr     <= '0;
`ifdef AXIS_SUM_EN
            sum_q      <= '0;
            sum_beat   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (!en) begin
                // Abort: contents and word_count are kept, no done pulse.
                state   <= ST_OFF;
                s_ready <= 1'b0;
                m_valid <= 1'b0;
                m_tlast <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    ST_OFF: begin
                        if (dma_valid) begin
                            state <= ST_IDLE;
                        end
                    end

                    ST_IDLE: begin
                        case (command)
                            CMD_IN: begin
                                state      <= ST_IN;
                                busy       <= 1'b1;
                                s_ready    <= 1'b1;
                                word_count <= '0;
                                target     <= (len == '0 || len > DEPTH_L) ? DEPTH_L : len;
`ifdef AXIS_SUM_EN
                                sum_q      <= '0;
`endif
                            end
                            CMD_OUT: begin
                                state  <= ST_OUT;
                                busy   <= 1'b1;
                                rd_ptr <= '0;
                            end
                            CMD_NOP: ;
                            default: ;
                        endcase
                    end

                    ST_IN: begin
                        if (beat_in) begin
                            word_count <= word_count + 1'b1;
`ifdef AXIS_SUM_EN
                            sum_q      <= sum_q + s_data;
`endif
                            if ((word_count + 1'b1) == target || s_tlast) begin
                                s_ready <= 1'b0;
                                state   <= ST_IN_W1;
                            end
                        end
                    end

                    ST_IN_W1: begin
                        if (!dma_valid) begin
                            state <= ST_IN_W2;
                        end
                    end

                    ST_IN_W2: begin
                        if (dma_valid) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end

                    ST_OUT: begin
                        if (load_beat) begin
                            m_valid  <= 1'b1;
                            m_tlast  <= (rd_ptr == total_beats - 1'b1);
                            rd_ptr   <= rd_ptr + 1'b1;
`ifdef AXIS_SUM_EN
                            sum_beat <= (rd_ptr == wc_ext);
`endif
                        end else if (out_free) begin
                            // All beats issued and the last one consumed
                            // (or there was nothing to send).
                            m_valid <= 1'b0;
                            m_tlast <= 1'b0;
                            state   <= ST_OUT_W1;
                        end
                    end

                    ST_OUT_W1: begin
                        if (!dma_valid) begin
                            state <= ST_OUT_W2;
                        end
                    end

                    ST_OUT_W2: begin
                        if (dma_valid) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end

                    default: begin
                        state <= ST_OFF;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axis_dma_buffer.sv
// ----------------------------------------------------------------------------
// tb_axis_dma_buffer
// Self-checking bench for axis_dma_buffer (DATA_W=32, DEPTH=32). Loaded words
// are mirrored into a small model; each OUT command pushes the expected beats
// into a scoreboard queue that a negedge monitor pops on every handshake.
// Define AXIS_SUM_EN for both bench and RTL to exercise the sum beat.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axis_dma_buffer;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;
    localparam int LEN_W  = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              dma_valid;
    logic [1:0]        command;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_tlast;
    logic              s_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_tlast;
    logic              m_ready;
    logic [LEN_W-1:0]  word_count;
    logic              busy;
    logic              done;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    beat_t             exp_q[$];
    logic [DATA_W-1:0] model_mem [DEPTH];
    int                model_count;
    logic [DATA_W-1:0] model_sum;

    int total = 0;
    int bad   = 0;

    axis_dma_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LEN_W  (LEN_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .dma_valid  (dma_valid),
        .command    (command),
        .len        (len),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_tlast    (s_tlast),
        .s_ready    (s_ready),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_tlast    (m_tlast),
        .m_ready    (m_ready),
        .word_count (word_count),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: sampled at negedge, away from the active edge.
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data  = '0;
    logic              prev_last  = 1'b0;

    always @(negedge clk) begin
        beat_t b;
        if (prev_stall) begin
            check("stall_valid", m_valid, 1);
            check("stall_data", m_data, prev_data);
            check("stall_last", m_tlast, prev_last);
        end
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_beat_qsize", exp_q.size(), 1);
            end else begin
                b = exp_q.pop_front();
                check("m_data", m_data, b.data);
                check("m_tlast", m_tlast, b.last);
            end
        end
        prev_stall <= m_valid && !m_ready;
        prev_data  <= m_data;
        prev_last  <= m_tlast;
    end

    task automatic dma_ack(input string tag);
        int dn = 0;
        dma_valid = 1'b0;
        tick();
        tick();
        dma_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done) dn++;
        end
        check({tag, "_done_pulses"}, dn, 1);
        check({tag, "_busy_end"}, busy, 0);
    endtask

    task automatic load(input string tag, input int n_beats, input int len_v,
                        input int tlast_at, input int base);
        int exp_n;
        exp_n = (len_v == 0 || len_v > DEPTH) ? DEPTH : len_v;
        if (tlast_at >= 0 && tlast_at + 1 < exp_n) exp_n = tlast_at + 1;
        command = 2'd1;
        len     = LEN_W'(len_v);
        tick();
        command = 2'd0;
        check({tag, "_busy"}, busy, 1);
        model_count = 0;
        model_sum   = '0;
        for (int i = 0; i < n_beats; i++) begin
            s_valid = 1'b1;
            s_data  = DATA_W'(base + i);
            s_tlast = (i == tlast_at);
            check({tag, "_s_ready"}, s_ready, (i < exp_n));
            if (i < exp_n) begin
                model_mem[i] = s_data;
                model_sum    = model_sum + s_data;
                model_count++;
            end
            tick();
        end
        s_valid = 1'b0;
        s_tlast = 1'b0;
        check({tag, "_s_ready_low"}, s_ready, 0);
        check({tag, "_word_count"}, word_count, exp_n);
        dma_ack(tag);
    endtask

    // mode 0: m_ready held high; mode 1: m_ready toggles every cycle.
    task automatic unload(input string tag, input int mode);
        beat_t b;
        int    n;
        int    vcyc = 0;
        int    cyc  = 0;
        for (int i = 0; i < model_count; i++) begin
            b.data = model_mem[i];
`ifdef AXIS_SUM_EN
            b.last = 1'b0;
`else
            b.last = (i == model_count - 1);
`endif
            exp_q.push_back(b);
        end
`ifdef AXIS_SUM_EN
        b.data = model_sum;
        b.last = 1'b1;
        exp_q.push_back(b);
`endif
        n = exp_q.size();
        command = 2'd2;
        tick();
        command = 2'd0;
        check({tag, "_busy"}, busy, 1);
        while (exp_q.size() > 0 && cyc < 400) begin
            m_ready = (mode == 0) ? 1'b1 : cyc[0];
            if (m_valid) vcyc++;
            tick();
            cyc++;
        end
        check({tag, "_remaining"}, exp_q.size(), 0);
        if (mode == 0) check({tag, "_gapless_cycles"}, vcyc, n);
        m_ready = 1'b0;
        check({tag, "_m_valid_end"}, m_valid, 0);
        exp_q.delete();
        dma_ack(tag);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dn;
        rst       = 1'b1;
        en        = 1'b0;
        dma_valid = 1'b0;
        command   = 2'd0;
        len       = '0;
        s_data    = '0;
        s_valid   = 1'b0;
        s_tlast   = 1'b0;
        m_ready   = 1'b0;
        model_count = 0;
        model_sum   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_tlast", m_tlast, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_m_data", m_data, 0);
        check("rst_word_count", word_count, 0);
        rst = 1'b0;
        tick();
        en        = 1'b1;
        dma_valid = 1'b1;
        tick();
        tick();

        // Empty buffer OUT: no data beats (single sum beat 0 with AXIS_SUM_EN).
        unload("empty", 0);

        // Full load of 0..31 with two surplus beats offered, then replay.
        load("t1", 34, 32, -1, 0);
        unload("t2", 0);

        // Early s_tlast on beat 5 of an 8-word load.
        load("t3", 8, 8, 5, 100);
        unload("t3r", 0);
        unload("t4", 1);

        // Abort with en=0 after 10 beats of a 20-word load.
        command = 2'd1;
        len     = LEN_W'(20);
        tick();
        command = 2'd0;
        model_count = 0;
        model_sum   = '0;
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1;
            s_data  = DATA_W'(200 + i);
            model_mem[i] = s_data;
            model_sum    = model_sum + s_data;
            model_count++;
            tick();
        end
        s_valid = 1'b0;
        en      = 1'b0;
        dn      = 0;
        tick();
        if (done) dn++;
        check("abort_s_ready", s_ready, 0);
        check("abort_word_count", word_count, 10);
        check("abort_busy", busy, 0);
        repeat (3) begin
            tick();
            if (done) dn++;
        end
        check("abort_no_done", dn, 0);
        en = 1'b1;
        tick();
        tick();
        unload("t5r", 1);

        // Length clamping: len=0 and len>DEPTH both mean DEPTH.
        load("t6", 32, 0, -1, 1000);
        unload("t6r", 0);
        load("t6b", 33, 40, -1, 32'h8000_0000);
        unload("t6br", 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
